if_stage: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly upstream of the decode stage. It owns the fetch PC and drives an SRAM-like instruction-memory request/response handshake. It presents one fetched instruction and its PC to decode, and applies decode's branch/jump redirect (`pcsource`, `bpc`, `jpc`, `jrpc`) with MIPS delay-slot semantics.

---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_stage_mux4x32.sv | 21 ++
 rtl/if_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: PC-source codes, reset PC and FSM encodings.
package if_stage_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JR  = 2'b10;
   localparam logic [1:0] PCSRC_J   = 2'b11;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      IF_IDLE = 2'b00,
      IF_REQ  = 2'b01,
      IF_WAIT = 2'b10
   } if_state_t;

endpackage

// File: rtl/if_stage_mux4x32.sv
// 4:1 selector of 32-bit words; s indexes a0..a3.
module mux4x32 (
   input  logic [31:0] a0,
   input  logic [31:0] a1,
   input  logic [31:0] a2,
   input  logic [31:0] a3,
   input  logic [1:0]  s,
   output logic [31:0] y
);

   always_comb begin
      y = a0;
      case (s)
         2'b00:   y = a0;
         2'b01:   y = a1;
         2'b10:   y = a2;
         default: y = a3;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: one outstanding SRAM-like request, single-entry output buffer,
// redirect applied to next_pc on consume so exactly one delay slot is fetched before the target.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] jrpc,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic [31:0] inst_rdata,
   input  logic        inst_data_ok,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic        o_valid
);

   if_state_t   r_state;
   if_state_t   w_state_nxt;
   logic [31:0] r_next_pc;
   logic [31:0] r_req_addr;
   logic [31:0] r_inst;
   logic [31:0] r_pc;
   logic        r_valid;

   logic        w_consume;
   logic        w_issue;
   logic        w_load;
   logic [31:0] w_seq_pc;
   logic [31:0] w_target;
   logic [31:0] w_next_pc_nxt;

   assign w_consume = r_valid && !stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IF_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         IF_IDLE: begin
            if (!r_valid || w_consume) begin
               w_state_nxt = IF_REQ;
               w_issue     = 1'b1;
            end
         end
         IF_REQ: begin
            if (inst_addr_ok) begin
               w_state_nxt = IF_WAIT;
            end
         end
         IF_WAIT: begin
            if (inst_data_ok) begin
               w_state_nxt = IF_IDLE;
               w_load      = 1'b1;
            end
         end
         default: w_state_nxt = IF_IDLE;
      endcase
   end

   // The issued request keeps the old next_pc (delay slot); a redirect only replaces the +4 step.
   assign w_seq_pc = w_issue ? (r_next_pc + 32'd4) : r_next_pc;

   mux4x32 u_target_mux (
      .a0 (w_seq_pc),
      .a1 (bpc),
      .a2 (jrpc),
      .a3 (jpc),
      .s  (pcsource),
      .y  (w_target)
   );

   assign w_next_pc_nxt = (w_consume && (pcsource != PCSRC_SEQ)) ? w_target : w_seq_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_next_pc  <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_inst     <= 32'h0;
         r_pc       <= 32'h0;
         r_valid    <= 1'b0;
      end else begin
         r_next_pc <= w_next_pc_nxt;
         if (w_issue) begin
            r_req_addr <= r_next_pc;
         end
         if (w_load) begin
            r_inst  <= inst_rdata;
            r_pc    <= r_req_addr;
            r_valid <= 1'b1;
         end else if (w_consume) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign inst_req  = (r_state == IF_REQ);
   assign inst_addr = r_req_addr;
   assign o_inst    = r_inst;
   assign o_pc      = r_pc;
   assign o_valid   = r_valid;

endmodule
